// File: rtl/freq_meter.sv
// -----------------------------------------------------------------------------
// freq_meter
//
// Gated frequency counter. Rising edges of the asynchronous sig_in are counted
// over back-to-back gate windows of GATE_CYCLES clocks. At the end of each
// window the count is presented on result together with a one-cycle trigger
// pulse, which the seven-segment display stage uses to latch the new value.
//
// Ports
//   CLK      in   system clock, all logic on the rising edge
//   reset    in   asynchronous active-low reset
//   enable   in   1 = measure continuously, 0 = stop and hold last result
//   sig_in   in   asynchronous signal under measurement
//   result   out  [31:0] edge count of the last completed window
//   trigger  out  one-cycle pulse; result is valid in the same cycle
//   overflow out  last completed window saturated at CNT_MAX
//   busy     out  a gate window is in progress
// -----------------------------------------------------------------------------
module freq_meter #(
  parameter int unsigned GATE_CYCLES = 100_000_000,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] CNT_MAX     = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        enable,
  input  logic        sig_in,
  output logic [31:0] result,
  output logic        trigger,
  output logic        overflow,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    COUNT = 2'd2,
    LATCH = 2'd3
  } state_t;

  // Last value of the gate counter is reached one cycle before the window
  // closes, so the window is GATE_CYCLES-1 COUNT cycles plus the LATCH cycle.
  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  state_t      state;
  state_t      state_n;

  logic [SYNC_STAGES-1:0] sync_q;
  logic        sync_out;
  logic        sync_prev;
  logic        edge_det;

  logic [31:0] edge_cnt;
  logic [31:0] gate_cnt;
  logic [31:0] latch_val;
  logic        gate_done;

  // ---------------------------------------------------------------------------
  // Synchronizer and edge detect
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments so all flops
  // update together on the edge and simulation order cannot change the result.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

  // sync_prev follows sync_out every cycle, ARM included, so a level that is
  // already high when a measurement starts never looks like an edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sync_prev <= 1'b0;
    end else begin
      sync_prev <= sync_out;
    end
  end

  assign edge_det = sync_out & ~sync_prev;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  assign gate_done = (gate_cnt == GATE_LAST - 32'd1);

  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (enable) state_n = ARM;
      ARM:     state_n = COUNT;
      COUNT: begin
        if (!enable)        state_n = IDLE;
        else if (gate_done) state_n = LATCH;
      end
      LATCH:   state_n = enable ? COUNT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Edge and gate counters
  // ---------------------------------------------------------------------------
  // Count including an edge detected in the current cycle, saturating.
  assign latch_val = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + 32'd1
                                                         : edge_cnt;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      edge_cnt <= '0;
      gate_cnt <= '0;
    end else if (state == COUNT) begin
      edge_cnt <= latch_val;
      gate_cnt <= gate_cnt + 32'd1;
    end else begin
      // LATCH hands its edge to result, so the next window starts from zero
      // and no edge is shared between windows.
      edge_cnt <= '0;
      gate_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      result   <= '0;
      overflow <= 1'b0;
      trigger  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      trigger <= (state == LATCH);
      busy    <= (state_n == COUNT) || (state_n == LATCH);
      if (state == LATCH) begin
        result   <= latch_val;
        overflow <= (latch_val == CNT_MAX);
      end
    end
  end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Reciprocal-free gated frequency counter that feeds the seven-segment display driver.
- Counts rising edges of an asynchronous external signal over a fixed gate window of GATE_CYCLES clocks.
- At the end of each window it presents the 32-bit binary count on result and pulses trigger for one cycle, so the display stage latches and converts the new value.
- Runs back-to-back windows with no dead time while enabled.

Parameters:
- GATE_CYCLES, 100_000_000, gate window length in CLK cycles (1 s at 100 MHz); legal range 2 to 2^32-1.
- SYNC_STAGES, 2, flip-flop stages in the sig_in synchronizer; legal range 2 to 4.
- CNT_MAX, 32'hFFFF_FFFF, saturation value of the edge counter.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = measure continuously; 0 = stop and hold last result.
- sig_in  input  1  asynchronous signal under measurement.
- result  output  32  binary edge count of the last completed window.
- trigger  output  1  one-cycle pulse; result is valid in the same cycle and stays stable until the next pulse.
- overflow  output  1  1 = the last completed window saturated at CNT_MAX.
- busy  output  1  1 = a gate window is in progress.

Behaviour:
- Reset values (reset=0, asynchronous): result=0, trigger=0, overflow=0, busy=0. The synchronizer chain, edge-detect register, edge counter and gate counter are all cleared. FSM goes to IDLE.
- Synchronizer: sig_in passes through SYNC_STAGES flops. Edge detect is sync_out & ~sync_prev, so an edge is counted SYNC_STAGES+1 clocks after it appears at the pin.
- States:
  - IDLE: busy=0. When enable=1, go to ARM.
  - ARM (1 cycle): clear the edge and gate counters, load sync_prev with the current sync_out so a high level is not counted as an edge. Go to COUNT.
  - COUNT: busy=1. Edge counter increments on each detected edge and saturates at CNT_MAX. Gate counter increments each cycle. When the gate counter reaches GATE_CYCLES-1, go to LATCH.
  - LATCH (1 cycle): result <= edge count, including any edge detected in this cycle. overflow <= (count == CNT_MAX). trigger=1. Counters clear. If enable=1, go to COUNT; else go to IDLE.
- Window length: exactly GATE_CYCLES clocks, from the first COUNT cycle through the LATCH cycle inclusive. No edge is lost or double-counted between consecutive windows.
- Trigger spacing in continuous mode: exactly GATE_CYCLES clocks between pulses.
- Abort: if enable falls during COUNT, go to IDLE on the next clock. The partial count is discarded, result and overflow hold, and no trigger is issued.
- Re-enable after IDLE always passes through ARM. The first trigger arrives 1+GATE_CYCLES clocks after the first cycle enable is sampled high.
- Saturation: the counter never wraps. overflow reflects only the most recent completed window.
- Reset mid-window: all state clears immediately and no trigger is issued.
- trigger is never asserted for two consecutive cycles.
- All outputs are registered.

Test Plan:
- Reset/idle (GATE_CYCLES=100): hold reset=0 then release with enable=0, toggle sig_in -> result=0, trigger=0, busy=0, overflow=0 throughout.
- Basic count: enable=1, sig_in period 10 clocks (50% duty), aligned so no edge sits at a window boundary -> trigger every 100 clocks, result=10 each window, overflow=0.
- Boundary edge: place a single edge so it is detected in the LATCH cycle -> it is counted in the closing window (result=1); the next window reports 0; the total over windows equals the edges driven.
- Saturation: CNT_MAX=32'd7, GATE_CYCLES=100, sig_in period 4 (25 edges) -> result=7, overflow=1. The following window with sig_in held low -> result=0, overflow=0.
- Abort and restart: deassert enable at clock 50 of a window -> no trigger, previous result held. Re-assert enable -> first trigger exactly 101 clocks after enable is sampled high.
- Async reset mid-window: pull reset low at clock 30 -> outputs are 0 before the next rising edge. After release with enable=1, counting restarts via ARM.
